// File: rtl/mcycle_unit_if.sv
// Request/result bundle between the Execute stage and the multi-cycle MUL/DIV unit.
interface mcycle_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Start;
  logic             MCycleOp;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [3:0]       WA3_In;
  logic [WIDTH-1:0] Result1;
  logic [WIDTH-1:0] Result2;
  logic             Busy;
  logic             Ready;
  logic [3:0]       WA3_MCycle;

  modport master (
    output Start, MCycleOp, Operand1, Operand2, WA3_In,
    input  Result1, Result2, Busy, Ready, WA3_MCycle
  );

  modport slave (
    input  Start, MCycleOp, Operand1, Operand2, WA3_In,
    output Result1, Result2, Busy, Ready, WA3_MCycle
  );
endinterface

// File: rtl/mcycle_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit, one bit per cycle.
// Results are published only on entry to DONE, with a one-cycle Ready pulse.
module mcycle_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic          CLK,
  input  logic          RESET,
  mcycle_unit_if.slave  bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]      count;
  logic               op;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   dvd;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   result1_q;
  logic [WIDTH-1:0]   result2_q;
  logic [3:0]         wa3_q;

  logic               accept;
  logic               last_iter;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH:0]     rem_sh;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   dvd_next;

  assign accept    = ((state == IDLE) || (state == DONE)) && bus.Start;
  assign last_iter = (count == CW'(WIDTH - 1));

  // Next-state and handshake outputs
  always_comb begin
    state_next = state;
    bus.Busy   = 1'b0;
    bus.Ready  = 1'b0;
    unique case (state)
      IDLE: begin
        bus.Busy = bus.Start;
        if (bus.Start) state_next = COMPUTE;
      end
      COMPUTE: begin
        bus.Busy = 1'b1;
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        bus.Ready = 1'b1;
        bus.Busy  = bus.Start;
        state_next = bus.Start ? COMPUTE : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One iteration of each algorithm; only the active op's result is published.
  // The dividend register doubles as the quotient register: dividend bits leave
  // at the top while quotient bits enter at the bottom.
  always_comb begin
    acc_next = mplier[0] ? (acc + mcand) : acc;
    rem_sh   = {rem, dvd[WIDTH-1]};
    q_bit    = (rem_sh >= {1'b0, divisor});
    rem_next = q_bit ? WIDTH'(rem_sh - {1'b0, divisor}) : WIDTH'(rem_sh);
    dvd_next = {dvd[WIDTH-2:0], q_bit};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count     <= '0;
      op        <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      divisor   <= '0;
      dvd       <= '0;
      rem       <= '0;
      result1_q <= '0;
      result2_q <= '0;
      wa3_q     <= '0;
    end else if (accept) begin
      count   <= '0;
      op      <= bus.MCycleOp;
      mcand   <= {{WIDTH{1'b0}}, bus.Operand1};
      mplier  <= bus.Operand2;
      acc     <= '0;
      divisor <= bus.Operand2;
      dvd     <= bus.Operand1;
      rem     <= '0;
      wa3_q   <= bus.WA3_In;
    end else if (state == COMPUTE) begin
      count  <= count + 1'b1;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_next;
      dvd    <= dvd_next;
      rem    <= rem_next;
      if (last_iter) begin
        result1_q <= op ? dvd_next : acc_next[WIDTH-1:0];
        result2_q <= op ? rem_next : acc_next[2*WIDTH-1:WIDTH];
      end
    end
  end

  assign bus.Result1    = result1_q;
  assign bus.Result2    = result2_q;
  assign bus.WA3_MCycle = wa3_q;
endmodule

// File: tb/tb_mcycle_unit.sv
// Directed self-checking bench for mcycle_unit: latency, MUL/DIV results, Start
// filtering, back-to-back ops and asynchronous reset abort.
module tb_mcycle_unit;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   n;
  int   bad;

  always #5 clk = ~clk;

  mcycle_unit_if #(.WIDTH(W)) bus ();

  mcycle_unit #(.WIDTH(W)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] tag);
    bus.Start    = 1'b1;
    bus.MCycleOp = op;
    bus.Operand1 = a;
    bus.Operand2 = b;
    bus.WA3_In   = tag;
  endtask

  task automatic launch(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] tag);
    drive(op, a, b, tag);
    @(posedge clk);
    #1 bus.Start = 1'b0;
  endtask

  // Counts falling edges from the accepting edge until Ready is seen (bounded).
  task automatic wait_ready(output int cnt);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cnt++;
      if (bus.Ready === 1'b1) break;
    end
  endtask

  task automatic count_ready(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.Ready !== 1'b0) cnt++;
    end
  endtask

  initial begin
    bus.Start    = 1'b0;
    bus.MCycleOp = 1'b0;
    bus.Operand1 = '0;
    bus.Operand2 = '0;
    bus.WA3_In   = '0;

    #1;
    check("rst_result1", bus.Result1, 0);
    check("rst_result2", bus.Result2, 0);
    check("rst_ready", bus.Ready, 0);
    check("rst_busy", bus.Busy, 0);
    check("rst_wa3", bus.WA3_MCycle, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // MUL 7 x 6: Busy window and exact latency
    drive(1'b0, 32'd7, 32'd6, 4'd5);
    #1 check("t1_busy_start", bus.Busy, 1);
    @(posedge clk);
    #1 bus.Start = 1'b0;
    bad = 0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (bus.Busy !== 1'b1 || bus.Ready !== 1'b0) bad++;
    end
    check("t1_busy_window", bad, 0);
    @(negedge clk);
    check("t1_ready", bus.Ready, 1);
    check("t1_busy_ready", bus.Busy, 0);
    check("t1_r1", bus.Result1, 42);
    check("t1_r2", bus.Result2, 0);
    check("t1_wa3", bus.WA3_MCycle, 5);
    @(negedge clk);
    check("t1_ready_pulse", bus.Ready, 0);
    check("t1_r1_hold", bus.Result1, 42);

    // MUL max x max
    launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2);
    wait_ready(n);
    check("t2_latency", n, W + 1);
    check("t2_r1", bus.Result1, 32'h0000_0001);
    check("t2_r2", bus.Result2, 32'hFFFF_FFFE);
    @(negedge clk);

    // DIV 100 / 7 and divide by zero
    launch(1'b1, 32'd100, 32'd7, 4'd6);
    wait_ready(n);
    check("t3_latency", n, W + 1);
    check("t3_q", bus.Result1, 14);
    check("t3_r", bus.Result2, 2);
    @(negedge clk);
    launch(1'b1, 32'd5, 32'd0, 4'd6);
    wait_ready(n);
    check("t3_div0_latency", n, W + 1);
    check("t3_div0_q", bus.Result1, 32'hFFFF_FFFF);
    check("t3_div0_r", bus.Result2, 5);
    @(negedge clk);

    // Start pulse during COMPUTE must be ignored
    launch(1'b0, 32'd3, 32'd3, 4'd4);
    repeat (5) @(negedge clk);
    drive(1'b1, 32'd9, 32'd2, 4'd9);
    #1 check("t4_busy_mid", bus.Busy, 1);
    @(posedge clk);
    #1 bus.Start = 1'b0;
    check("t4_wa3_mid", bus.WA3_MCycle, 4);
    wait_ready(n);
    check("t4_ready_seen", bus.Ready, 1);
    check("t4_r1", bus.Result1, 9);
    check("t4_r2", bus.Result2, 0);
    check("t4_wa3", bus.WA3_MCycle, 4);
    count_ready(W + 4, bad);
    check("t4_single_ready", bad, 0);

    // Back-to-back: Start accepted in the Ready cycle
    launch(1'b0, 32'd10, 32'd10, 4'd1);
    wait_ready(n);
    check("t5_first_latency", n, W + 1);
    check("t5_first_r1", bus.Result1, 100);
    drive(1'b1, 32'd9, 32'd2, 4'd3);
    #1;
    check("t5_ready_b2b", bus.Ready, 1);
    check("t5_busy_b2b", bus.Busy, 1);
    check("t5_first_r1_hold", bus.Result1, 100);
    @(posedge clk);
    #1 bus.Start = 1'b0;
    check("t5_r1_after_accept", bus.Result1, 100);
    wait_ready(n);
    check("t5_latency", n, W + 1);
    check("t5_q", bus.Result1, 4);
    check("t5_r", bus.Result2, 1);
    check("t5_wa3", bus.WA3_MCycle, 3);
    @(negedge clk);

    // Asynchronous reset at iteration 10 aborts the op
    launch(1'b0, 32'h1234, 32'h5678, 4'd7);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_r1", bus.Result1, 0);
    check("t6_rst_r2", bus.Result2, 0);
    check("t6_rst_ready", bus.Ready, 0);
    check("t6_rst_busy", bus.Busy, 0);
    check("t6_rst_wa3", bus.WA3_MCycle, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    count_ready(W + 4, bad);
    check("t6_no_ready", bad, 0);
    launch(1'b0, 32'h1234, 32'h5678, 4'd7);
    wait_ready(n);
    check("t6_latency", n, W + 1);
    check("t6_r1", bus.Result1, 32'h0626_0060);
    check("t6_r2", bus.Result2, 0);
    check("t6_wa3", bus.WA3_MCycle, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
